// File: rtl/uart_boot_loader.sv
// UART (8N1) boot loader: packs received bytes into little-endian words and writes them to memory.
// Optional feature macro: UART_BOOT_FRAME_CHECK_EN (stop-bit check, frame_err_o).
module uart_boot_loader #(
  parameter int          CLKS_PER_BIT = 869,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          TIMEOUT_BITS = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        uart_rx_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_gnt_i,
  output logic        boot_done_o,
  output logic        core_rst_no,
  output logic [15:0] word_count_o,
  output logic        overrun_o,
  output logic        frame_err_o
);
  localparam int HALF_BIT    = CLKS_PER_BIT / 2;
  localparam int TIMEOUT_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CW          = $clog2(CLKS_PER_BIT + 1);
  localparam int IW          = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_next;
  logic          sync1, rx;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          start_edge, cnt_clr, bit_sample, byte_vld, byte_ok;
  logic [1:0]    idx;
  logic [31:0]   word, pad_mask;
  logic [IW-1:0] idle_cnt;
  logic          idle_run, timeout_hit, timed_out, req, done;

  function automatic logic [3:0] partial_be(input logic [1:0] n);
    return (4'd1 << n) - 4'd1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1 <= 1'b1;
      rx    <= 1'b1;
    end else begin
      sync1 <= uart_rx_i;
      rx    <= sync1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  // Receiver stays parked in IDLE once loading has timed out.
  always_comb begin
    state_next = state;
    start_edge = 1'b0;
    cnt_clr    = 1'b0;
    bit_sample = 1'b0;
    byte_vld   = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!timed_out && !rx) begin
          start_edge = 1'b1;
          state_next = START;
        end
      end
      START: if (clk_cnt == HALF_LAST) begin
        cnt_clr    = 1'b1;
        state_next = rx ? IDLE : DATA;
      end
      DATA: if (clk_cnt == BIT_LAST) begin
        cnt_clr    = 1'b1;
        bit_sample = 1'b1;
        if (bit_idx == 3'd7) state_next = STOP;
      end
      STOP: if (clk_cnt == BIT_LAST) begin
        cnt_clr    = 1'b1;
        byte_vld   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      clk_cnt <= cnt_clr ? '0 : clk_cnt + CW'(1);
      if (state == IDLE) begin
        bit_idx <= '0;
      end else if (bit_sample) begin
        bit_idx <= bit_idx + 3'd1;
        shift   <= {rx, shift[7:1]};
      end
    end
  end

`ifdef UART_BOOT_FRAME_CHECK_EN
  logic frame_err;
  assign byte_ok     = byte_vld & rx;
  assign frame_err_o = frame_err;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)              frame_err <= 1'b0;
    else if (byte_vld && !rx) frame_err <= 1'b1;
  end
`else
  assign byte_ok     = byte_vld;
  assign frame_err_o = 1'b0;
`endif

  // Idle time only accrues once something has been received and the write port is quiet.
  assign idle_run    = (state == IDLE) && (word_count_o != 16'd0 || idx != 2'd0) && !req && !timed_out;
  assign timeout_hit = idle_run && (idle_cnt == IDLE_LAST);

  always_comb begin
    pad_mask = '0;
    for (int j = 0; j < 4; j++)
      if (j < int'(idx)) pad_mask[8*j +: 8] = 8'hFF;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx          <= '0;
      word         <= '0;
      idle_cnt     <= '0;
      timed_out    <= 1'b0;
      req          <= 1'b0;
      done         <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      mem_be_o     <= '0;
      word_count_o <= '0;
      overrun_o    <= 1'b0;
    end else begin
      if (start_edge)    idle_cnt <= '0;
      else if (idle_run) idle_cnt <= idle_cnt + IW'(1);

      if (req && mem_gnt_i) begin
        req          <= 1'b0;
        word_count_o <= word_count_o + 16'd1;
      end

      if (byte_ok) begin
        word[{idx, 3'b000} +: 8] <= shift;
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          if (req) begin
            overrun_o <= 1'b1;
          end else begin
            req         <= 1'b1;
            mem_addr_o  <= BASE_ADDR + {14'd0, word_count_o, 2'b00};
            mem_wdata_o <= {shift, word[23:0]};
            mem_be_o    <= 4'hF;
          end
        end
      end

      // Stale upper lanes of word are masked off for the final partial write.
      if (timeout_hit) begin
        timed_out <= 1'b1;
        if (idx != 2'd0) begin
          req         <= 1'b1;
          mem_addr_o  <= BASE_ADDR + {14'd0, word_count_o, 2'b00};
          mem_wdata_o <= word & pad_mask;
          mem_be_o    <= partial_be(idx);
          idx         <= '0;
        end
      end

      if (timed_out && !req) done <= 1'b1;
    end
  end

  assign mem_req_o   = req;
  assign mem_we_o    = req;
  assign boot_done_o = done;
  assign core_rst_no = done;

endmodule
